uart_mem_bridge: RTL and testbench
==================================

// Module: uart_mem_bridge
// PURPOSE
//  Byte-command bridge between the UART byte layer and one port of a dual-port data RAM (port B side).
//  - Host sends opcode/address/count/data bytes; block performs single or burst word writes/reads
//    and streams read data back as bytes.
//  - Generalises the fixed 18-bit/1k host-access path: word and address widths, RAM read latency
//    and burst length are parametric; adds burst auto-increment, LED command, inter-byte timeout.
// PARAMETERS
//  DATA_WIDTH      18        RAM word width, 1..32
//  ADDR_WIDTH      18        RAM address width, 1..32
//  READ_LATENCY    1         cycles from mem_address valid to mem_read valid, 1..3
//  TIMEOUT_CYCLES  500000    max idle cycles between rx bytes inside a command (10 ms @50 MHz)
//  Derived: DB = ceil(DATA_WIDTH/8) bytes per word; AB = ceil(ADDR_WIDTH/8) address bytes.
// PORTS
//  clk_50M      in   1           system clock
//  reset        in   1           asynchronous, active-high reset
//  rx_data      in   8           received byte
//  rx_valid     in   1           1-cycle strobe, rx_data valid; no backpressure
//  tx_data      out  8           byte to transmit
//  tx_valid     out  1           tx_data valid; held until tx_ready
//  tx_ready     in   1           transmitter accepts byte when tx_valid&tx_ready
//  mem_address  out  ADDR_WIDTH  RAM address
//  mem_write    out  DATA_WIDTH  RAM write data
//  mem_wren     out  1           RAM write enable, 1-cycle pulse per word
//  mem_read     in   DATA_WIDTH  RAM read data (READ_LATENCY after address)
//  ledout       out  8           LED register
//  busy         out  1           high whenever state != IDLE
//  err          out  1           1-cycle pulse: bad opcode or timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, addr/count/shift registers 0. Asserting reset mid-command aborts
//    it; no further mem_wren, tx_valid drops immediately.
//  - Multi-byte fields are little-endian. Unused high bits of the last address/data byte are ignored
//    on rx and sent as 0 on tx.
//  - Opcodes (first byte in IDLE): 0x01 WRITE, 0x02 READ, 0x03 LED. Any other value: err pulse, stay IDLE.
//  - WRITE: AB addr bytes, 1 count byte C, then (C+1) words of DB bytes.
//    Per word: mem_wren=1 for exactly 1 cycle, the cycle after the last byte of that word; address
//    increments after each write.
//  - READ: AB addr bytes, count C. Then (C+1) words: drive mem_address, wait READ_LATENCY cycles,
//    capture mem_read, send DB bytes LSB-first, then increment address.
//  - LED: 1 byte -> ledout, updated the cycle after that byte's rx_valid.
//  - Bursts: 1..256 words. Address wraps modulo 2^ADDR_WIDTH (all-ones + 1 -> 0).
//  - States: IDLE, ADDR, COUNT, WDATA, WSTROBE, RADDR, RWAIT, RSEND, LEDB.
//  - Transitions:
//    - IDLE->ADDR/LEDB on opcode; ADDR->COUNT after AB bytes.
//    - COUNT->WDATA (write) or RADDR (read).
//    - WDATA->WSTROBE after DB bytes; WSTROBE->WDATA, or IDLE when the count is exhausted.
//    - RADDR->RWAIT->RSEND; RSEND->RADDR, or IDLE after the last byte handshake.
//  - Timeout:
//    - Counter runs in ADDR, COUNT, WDATA, LEDB; reset by each rx_valid.
//    - Reaching TIMEOUT_CYCLES: err pulse, IDLE; a partially received write word is discarded.
//    - Counter is not active in read states.
//  - rx_valid during RADDR/RWAIT/RSEND/WSTROBE: byte dropped silently (host must wait for the reply).
//  - tx: a byte stays stable while tx_valid=1 and !tx_ready; next byte is presented at the earliest
//    the cycle after the handshake.
//  - mem_write is stable whenever mem_wren=1; mem_address is held during RWAIT.
// STRUCTURE
//  - Package uart_mem_bridge_pkg:
//    - state enum;
//    - opcode localparams OP_WRITE/OP_READ/OP_LED;
//    - function bytes_for(width) = ceil(width/8).
//  - Sub-module word_serdes #(DATA_WIDTH): byte<->word shift register with byte counter (load word /
//    shift out LSB byte; shift in byte / word_done). Top file holds FSM, addr/count, timeout counter.
// TESTING
//  - Write single: 01 10 00 00 00 AA BB 03 -> one mem_wren, addr 0x00010, data 0x3BBAA; busy low after.
//  - Burst read: preload 0x00100..0x00102 = 1,2,3; send 02 00 01 00 02
//    -> tx 01 00 00 02 00 00 03 00 00, random tx_ready stalls, bytes unchanged while stalled.
//  - Wrap: write C=1 at addr 0x3FFFF -> mem_wren at 0x3FFFF then 0x00000.
//  - Error/timeout: opcode 0x7F -> err pulse, IDLE; 01 05 then silence TIMEOUT_CYCLES -> err, no
//    mem_wren; next 03 5A -> ledout 0x5A.
//  - Reset mid-burst-read: assert reset during RSEND -> tx_valid, busy, mem_wren 0 at once; next
//    command works.
//  - Params DATA_WIDTH=8, ADDR_WIDTH=10, READ_LATENCY=2: read/write roundtrip with DB=1, AB=2 matches RAM model.

Source files
------------

// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART byte-command to RAM bridge.
package uart_mem_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_WDATA,
    S_WSTROBE,
    S_RADDR,
    S_RWAIT,
    S_RSEND,
    S_LEDB
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_LED   = 8'h03;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_mem_bridge_word_serdes.sv
// Byte<->word shift register: assembles little-endian rx bytes into a word, or
// streams a loaded word out LSB byte first. Padding bits above DATA_WIDTH are zero on load.
module word_serdes
  import uart_mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_shift_in,
  input  logic [7:0]            i_byte,
  input  logic                  i_shift_out,
  output logic [7:0]            o_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_last
);

  localparam int         DB       = bytes_for(DATA_WIDTH);
  localparam int         SW       = DB * 8;
  localparam logic [2:0] LAST_IDX = 3'(DB - 1);

  logic [SW-1:0] r_sh;
  logic [2:0]    r_idx;
  logic [SW-1:0] w_sh_in;

  // New bytes enter at the top so the first byte received ends up in bits [7:0].
  assign w_sh_in = (r_sh >> 8) | (SW'(i_byte) << (SW - 8));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sh  <= SW'(i_word);
      r_idx <= '0;
    end else if (i_shift_in || i_shift_out) begin
      r_sh  <= i_shift_in ? w_sh_in : (r_sh >> 8);
      r_idx <= o_last ? 3'd0 : r_idx + 3'd1;
    end
  end

  assign o_byte = r_sh[7:0];
  assign o_word = r_sh[DATA_WIDTH-1:0];
  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/uart_mem_bridge.sv
// Byte-command bridge from the UART byte layer to one RAM port: single/burst word
// writes and reads with little-endian fields, LED register and inter-byte timeout.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 18,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_read,
  output logic [7:0]            ledout,
  output logic                  busy,
  output logic                  err
);

  localparam int          AB       = bytes_for(ADDR_WIDTH);
  localparam int          ASW      = AB * 8;
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  ALAST    = 3'(AB - 1);
  localparam logic [1:0]  RL       = 2'(READ_LATENCY);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic                  r_is_read;
  logic [ASW-1:0]        r_ash;
  logic [2:0]            r_abyte;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cnt;
  logic [1:0]            r_rw;
  logic [TW-1:0]         r_tmo;
  logic                  r_tx_valid;
  logic                  r_mem_wren;
  logic [7:0]            r_ledout;
  logic                  r_err;

  logic [ASW-1:0]        w_ash_nxt;
  logic                  w_tmo_en;
  logic                  w_tmo_hit;
  logic                  w_clr;
  logic                  w_load;
  logic                  w_shin;
  logic                  w_shout;
  logic [7:0]            w_tx_byte;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_last;

  assign w_ash_nxt = (r_ash >> 8) | (ASW'(rx_data) << (ASW - 8));
  assign w_tmo_en  = r_state inside {S_ADDR, S_COUNT, S_WDATA, S_LEDB};
  assign w_tmo_hit = w_tmo_en && !rx_valid && (r_tmo == TMO_LAST);

  // Clearing in IDLE discards any partial word left behind by a timeout.
  assign w_clr   = (r_state == S_IDLE);
  assign w_load  = (r_state == S_RWAIT) && (r_rw == RL);
  assign w_shin  = (r_state == S_WDATA) && rx_valid;
  assign w_shout = (r_state == S_RSEND) && r_tx_valid && tx_ready;

  word_serdes #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serdes (
    .clk        (clk_50M),
    .rst        (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_word     (mem_read),
    .i_shift_in (w_shin),
    .i_byte     (rx_data),
    .i_shift_out(w_shout),
    .o_byte     (w_tx_byte),
    .o_word     (w_word),
    .o_last     (w_last)
  );

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_read  <= 1'b0;
      r_ash      <= '0;
      r_abyte    <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rw       <= '0;
      r_tmo      <= '0;
      r_tx_valid <= 1'b0;
      r_mem_wren <= 1'b0;
      r_ledout   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_mem_wren <= 1'b0;
      if (w_tmo_en && !rx_valid) r_tmo <= r_tmo + 1'b1;
      else                       r_tmo <= '0;

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              r_is_read <= (rx_data == OP_READ);
              r_abyte   <= '0;
              r_state   <= S_ADDR;
            end else if (rx_data == OP_LED) begin
              r_state <= S_LEDB;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_ash <= w_ash_nxt;
            if (r_abyte == ALAST) begin
              r_addr  <= w_ash_nxt[ADDR_WIDTH-1:0];
              r_state <= S_COUNT;
            end else begin
              r_abyte <= r_abyte + 3'd1;
            end
          end
        end
        S_COUNT: begin
          if (rx_valid) begin
            r_cnt   <= rx_data;
            r_state <= r_is_read ? S_RADDR : S_WDATA;
          end
        end
        S_WDATA: begin
          if (rx_valid && w_last) begin
            r_mem_wren <= 1'b1;
            r_state    <= S_WSTROBE;
          end
        end
        S_WSTROBE: begin
          r_addr <= r_addr + 1'b1;
          if (r_cnt == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
            r_state <= S_WDATA;
          end
        end
        S_RADDR: begin
          r_rw    <= 2'd1;
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (r_rw == RL) begin
            r_tx_valid <= 1'b1;
            r_state    <= S_RSEND;
          end else begin
            r_rw <= r_rw + 2'd1;
          end
        end
        S_RSEND: begin
          if (r_tx_valid && tx_ready && w_last) begin
            r_tx_valid <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            if (r_cnt == 8'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= S_RADDR;
            end
          end
        end
        S_LEDB: begin
          if (rx_valid) begin
            r_ledout <= rx_data;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_tmo_hit) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

  assign tx_data     = w_tx_byte;
  assign tx_valid    = r_tx_valid;
  assign mem_address = r_addr;
  assign mem_write   = w_word;
  assign mem_wren    = r_mem_wren;
  assign ledout      = r_ledout;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: an 18/18/L1 instance and an 8/10/L2 instance,
// each with a behavioural RAM, write log and tx byte capture.
module tb_uart_mem_bridge;

  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a, rx_valid_a, tx_valid_a, tx_ready_a, wren_a, busy_a, err_a;
  logic [7:0]  rx_data_a, tx_data_a, led_a;
  logic [17:0] addr_a, wdata_a, rdata_a;

  logic        rst_b, rx_valid_b, tx_valid_b, tx_ready_b, wren_b, busy_b, err_b;
  logic [7:0]  rx_data_b, tx_data_b, led_b;
  logic [9:0]  addr_b;
  logic [7:0]  wdata_b, rdata_b;

  logic [17:0] mem_a [0:262143];
  logic [7:0]  mem_b [0:1023];
  logic [17:0] rd_a_p1;
  logic [7:0]  rd_b_p1, rd_b_p2;
  logic        pk_we_a, pk_we_b;
  logic [17:0] pk_addr_a, pk_data_a;
  logic [9:0]  pk_addr_b;
  logic [7:0]  pk_data_b;

  logic [35:0] wlog_a[$];
  logic [17:0] wlog_b[$];
  logic [7:0]  txq_a[$];
  logic [7:0]  txq_b[$];

  assign rdata_a = rd_a_p1;
  assign rdata_b = rd_b_p2;

  always @(posedge clk) begin
    rd_a_p1 <= mem_a[addr_a];
    rd_b_p1 <= mem_b[addr_b];
    rd_b_p2 <= rd_b_p1;
    if (wren_a) begin
      mem_a[addr_a] = wdata_a;
      wlog_a.push_back({addr_a, wdata_a});
    end
    if (wren_b) begin
      mem_b[addr_b] = wdata_b;
      wlog_b.push_back({addr_b, wdata_b});
    end
    if (pk_we_a) mem_a[pk_addr_a] = pk_data_a;
    if (pk_we_b) mem_b[pk_addr_b] = pk_data_b;
    if (tx_valid_a && tx_ready_a) txq_a.push_back(tx_data_a);
    if (tx_valid_b && tx_ready_b) txq_b.push_back(tx_data_b);
  end

  uart_mem_bridge #(
    .DATA_WIDTH(18), .ADDR_WIDTH(18), .READ_LATENCY(1), .TIMEOUT_CYCLES(TMO)
  ) u_a (
    .clk_50M(clk), .reset(rst_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .mem_address(addr_a), .mem_write(wdata_a), .mem_wren(wren_a), .mem_read(rdata_a),
    .ledout(led_a), .busy(busy_a), .err(err_a)
  );

  uart_mem_bridge #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .READ_LATENCY(2), .TIMEOUT_CYCLES(TMO)
  ) u_b (
    .clk_50M(clk), .reset(rst_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .mem_address(addr_b), .mem_write(wdata_b), .mem_wren(wren_b), .mem_read(rdata_b),
    .ledout(led_b), .busy(busy_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nogap(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin rx_data_b = b; rx_valid_b = 1'b1; end
    else     begin rx_data_a = b; rx_valid_a = 1'b1; end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    send_nogap(sel, b);
    repeat (3) @(negedge clk);
  endtask

  task automatic poke_a(input logic [17:0] a, input logic [17:0] d);
    @(negedge clk);
    pk_addr_a = a; pk_data_a = d; pk_we_a = 1'b1;
    @(negedge clk);
    pk_we_a = 1'b0;
  endtask

  task automatic poke_b(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_addr_b = a; pk_data_b = d; pk_we_b = 1'b1;
    @(negedge clk);
    pk_we_b = 1'b0;
  endtask

  // Collect n tx bytes under random backpressure; a stalled byte must hold.
  task automatic collect(input bit sel, input int n, input int budget);
    logic [7:0] hold;
    bit         stalled;
    bit         rdy;
    int         cyc;
    stalled = 1'b0;
    hold    = 8'h00;
    cyc     = 0;
    while (((sel ? txq_b.size() : txq_a.size()) < n) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("tx_hold_valid", sel ? tx_valid_b : tx_valid_a, 1'b1);
        check("tx_hold_data", sel ? tx_data_b : tx_data_a, hold);
      end
      rdy = 1'($urandom_range(0, 1));
      if (sel) tx_ready_b = rdy; else tx_ready_a = rdy;
      stalled = (sel ? tx_valid_b : tx_valid_a) && !rdy;
      hold    = sel ? tx_data_b : tx_data_a;
    end
    check("tx_count", sel ? txq_b.size() : txq_a.size(), n);
    tx_ready_a = 1'b0;
    tx_ready_b = 1'b0;
  endtask

  task automatic wait_err_a(output int k);
    k = 0;
    while (!err_a && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    logic [7:0] exp_rd [0:8];
    rst_a = 1'b1; rst_b = 1'b1;
    rx_valid_a = 1'b0; rx_valid_b = 1'b0; rx_data_a = '0; rx_data_b = '0;
    tx_ready_a = 1'b0; tx_ready_b = 1'b0;
    pk_we_a = 1'b0; pk_we_b = 1'b0; pk_addr_a = '0; pk_data_a = '0; pk_addr_b = '0; pk_data_b = '0;
    poke_a(18'h00100, 18'd1);
    poke_a(18'h00101, 18'd2);
    poke_a(18'h00102, 18'd3);
    poke_b(10'h001, 8'h77);

    check("rst_tx_valid", tx_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_wren", wren_a, 1'b0);
    check("rst_led", led_a, 8'h00);
    check("rst_tx_data", tx_data_a, 8'h00);
    check("rst_addr", addr_a, 18'h0);
    check("rst_b_busy", busy_b, 1'b0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Single write, with mem_wren timing against the last data byte.
    wlog_a.delete();
    send(0, 8'h01);
    check("wr_busy_mid", busy_a, 1'b1);
    send(0, 8'h10); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h00);
    send(0, 8'hAA); send(0, 8'hBB);
    send_nogap(0, 8'h03);
    check("wr_wren_pulse", wren_a, 1'b1);
    check("wr_addr", addr_a, 18'h00010);
    check("wr_data", wdata_a, 18'h3BBAA);
    @(negedge clk);
    check("wr_wren_one_cycle", wren_a, 1'b0);
    check("wr_busy_after", busy_a, 1'b0);
    check("wr_log_size", wlog_a.size(), 1);

    // Burst read of three words with random stalls.
    txq_a.delete();
    send(0, 8'h02); send(0, 8'h00); send(0, 8'h01); send(0, 8'h00); send(0, 8'h02);
    collect(0, 9, 600);
    exp_rd = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) check("rd_byte", (txq_a.size() > i) ? txq_a[i] : 8'hxx, exp_rd[i]);
    @(negedge clk);
    check("rd_busy_after", busy_a, 1'b0);
    check("rd_tx_valid_after", tx_valid_a, 1'b0);

    // Two-word burst write wrapping past the top of the address space.
    wlog_a.delete();
    send(0, 8'h01); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'h03); send(0, 8'h01);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h01);
    send(0, 8'h55); send(0, 8'h66); send(0, 8'hFF);
    check("wrap_log_size", wlog_a.size(), 2);
    check("wrap_w0", (wlog_a.size() > 0) ? wlog_a[0] : 36'h0, {18'h3FFFF, 18'h12211});
    check("wrap_w1", (wlog_a.size() > 1) ? wlog_a[1] : 36'h0, {18'h00000, 18'h36655});
    check("wrap_busy_after", busy_a, 1'b0);

    // Bad opcode.
    send_nogap(0, 8'h7F);
    check("badop_err", err_a, 1'b1);
    check("badop_busy", busy_a, 1'b0);
    @(negedge clk);
    check("badop_err_pulse", err_a, 1'b0);

    // Timeout inside the address field, then an LED command.
    wlog_a.delete();
    send(0, 8'h01); send(0, 8'h05);
    check("tmo_busy", busy_a, 1'b1);
    wait_err_a(k);
    check("tmo_err_seen", err_a, 1'b1);
    check("tmo_latency", (k >= 60 && k <= 62), 1'b1);
    check("tmo_busy_after", busy_a, 1'b0);
    send(0, 8'h03); send(0, 8'h5A);
    check("led_value", led_a, 8'h5A);
    check("tmo_no_wren", wlog_a.size(), 0);

    // Timeout with a partial data word must not leak into the next write.
    send(0, 8'h01); send(0, 8'h20); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'hAA);
    wait_err_a(k);
    check("tmo2_err_seen", err_a, 1'b1);
    check("tmo2_no_wren", wlog_a.size(), 0);
    send(0, 8'h01); send(0, 8'h30); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h03);
    check("tmo2_next_write", (wlog_a.size() > 0) ? wlog_a[0] : 36'h0, {18'h00030, 18'h32211});

    // Asynchronous reset in the middle of a read reply.
    txq_a.delete();
    tx_ready_a = 1'b0;
    send(0, 8'h02); send(0, 8'h00); send(0, 8'h01); send(0, 8'h00); send(0, 8'h02);
    k = 0;
    while (!tx_valid_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mrst_tx_valid_before", tx_valid_a, 1'b1);
    #2 rst_a = 1'b1;
    #1;
    check("mrst_tx_valid", tx_valid_a, 1'b0);
    check("mrst_busy", busy_a, 1'b0);
    check("mrst_wren", wren_a, 1'b0);
    check("mrst_led", led_a, 8'h00);
    @(negedge clk);
    rst_a = 1'b0;
    txq_a.delete();
    send(0, 8'h02); send(0, 8'h01); send(0, 8'h01); send(0, 8'h00); send(0, 8'h00);
    collect(0, 3, 200);
    check("mrst_rd_b0", (txq_a.size() > 0) ? txq_a[0] : 8'hxx, 8'h02);
    check("mrst_rd_b1", (txq_a.size() > 1) ? txq_a[1] : 8'hxx, 8'h00);

    // Narrow instance: DB=1, AB=2, read latency 2, wrapping burst.
    wlog_b.delete();
    send(1, 8'h01); send(1, 8'hFE); send(1, 8'h03); send(1, 8'h02);
    send(1, 8'hA1); send(1, 8'hB2); send(1, 8'hC3);
    check("b_wr_log_size", wlog_b.size(), 3);
    check("b_wr0", (wlog_b.size() > 0) ? wlog_b[0] : 18'h0, {10'h3FE, 8'hA1});
    check("b_wr1", (wlog_b.size() > 1) ? wlog_b[1] : 18'h0, {10'h3FF, 8'hB2});
    check("b_wr2", (wlog_b.size() > 2) ? wlog_b[2] : 18'h0, {10'h000, 8'hC3});
    txq_b.delete();
    send(1, 8'h02); send(1, 8'hFE); send(1, 8'h03); send(1, 8'h03);
    collect(1, 4, 400);
    check("b_rd0", (txq_b.size() > 0) ? txq_b[0] : 8'hxx, 8'hA1);
    check("b_rd1", (txq_b.size() > 1) ? txq_b[1] : 8'hxx, 8'hB2);
    check("b_rd2", (txq_b.size() > 2) ? txq_b[2] : 8'hxx, 8'hC3);
    check("b_rd3", (txq_b.size() > 3) ? txq_b[3] : 8'hxx, 8'h77);
    @(negedge clk);
    check("b_busy_after", busy_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
